// File: rtl/row_group_sched_pkg.sv
// Shared types and width helpers for the row-group scheduler.
package row_group_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_RAMP   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic int row_id_width(input int router_count);
      return (router_count > 1) ? $clog2(router_count) : 1;
   endfunction

   // Wide enough for the last lane's start threshold plus one saturating step.
   function automatic int cnt_width(input int router_count, input int skew_w);
      return $clog2((router_count - 1) * ((2 ** skew_w) - 1) + 2);
   endfunction

endpackage

// File: rtl/row_group_sched_if.sv
// Control, address-generator and lane-status bundle of the row-group scheduler.
interface row_group_sched_if
   import row_group_sched_pkg::*;
#(
   parameter int ROUTER_COUNT = 4,
   parameter int SKEW_W       = 4,
   parameter int ROW_ID_W     = row_id_width(ROUTER_COUNT)
);
   logic                    i_reg_clear;
   logic                    i_start;
   logic [SKEW_W-1:0]       i_skew;
   logic                    i_stall;
   logic                    i_ag_valid;
   logic [ROW_ID_W-1:0]     i_row_id;
   logic [ROUTER_COUNT-1:0] i_lane_addr_empty;
   logic [ROUTER_COUNT-1:0] i_lane_data_empty;
   logic [ROUTER_COUNT-1:0] o_lane_write_en;
   logic [ROUTER_COUNT-1:0] o_lane_pop_en;
   logic [2:0]              o_state;
   logic                    o_busy;
   logic                    o_done;
   logic                    o_addr_empty;
   logic                    o_data_empty;
   logic [31:0]             o_stall_cycles;
   logic [31:0]             o_busy_cycles;

   modport master (
      output i_reg_clear, i_start, i_skew, i_stall, i_ag_valid, i_row_id,
             i_lane_addr_empty, i_lane_data_empty,
      input  o_lane_write_en, o_lane_pop_en, o_state, o_busy, o_done,
             o_addr_empty, o_data_empty, o_stall_cycles, o_busy_cycles
   );

   modport slave (
      input  i_reg_clear, i_start, i_skew, i_stall, i_ag_valid, i_row_id,
             i_lane_addr_empty, i_lane_data_empty,
      output o_lane_write_en, o_lane_pop_en, o_state, o_busy, o_done,
             o_addr_empty, o_data_empty, o_stall_cycles, o_busy_cycles
   );

endinterface

// File: rtl/row_group_sched_skew_pop_gen.sv
// Ramp counter and staggered per-lane pop enables: lane k may pop once the
// counter of unstalled run cycles reaches k*skew.
module row_group_sched_skew_pop_gen
   import row_group_sched_pkg::*;
#(
   parameter int ROUTER_COUNT = 4,
   parameter int SKEW_W       = 4,
   parameter int CNT_W        = cnt_width(ROUTER_COUNT, SKEW_W)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clear,
   input  logic                    i_run,
   input  logic                    i_stall,
   input  logic [SKEW_W-1:0]       i_skew,
   input  logic [ROUTER_COUNT-1:0] i_lane_empty,
   output logic [ROUTER_COUNT-1:0] o_pop_en,
   output logic                    o_ramp_done
);

   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        skew_ext;
   logic [ROUTER_COUNT-1:0] pop_next;
   logic [ROUTER_COUNT-1:0] pop_en_q;

   assign skew_ext = CNT_W'(i_skew);

   // NOTE: every variable driven in always_comb gets a default first, so no path leaves it holding a value (no latch).
   always_comb begin
      pop_next = '0;
      for (int k = 0; k < ROUTER_COUNT; k++) begin
         pop_next[k] = (cnt_q >= CNT_W'(k) * skew_ext) & ~i_lane_empty[k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q    <= '0;
         pop_en_q <= '0;
      end else if (i_clear || !i_run) begin
         cnt_q    <= '0;
         pop_en_q <= '0;
      end else if (i_stall) begin
         pop_en_q <= '0;
      end else begin
         pop_en_q <= pop_next;
         if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign o_pop_en    = pop_en_q;
   assign o_ramp_done = (cnt_q == CNT_W'(ROUTER_COUNT - 1) * skew_ext);

endmodule

// File: rtl/row_group_sched.sv
// Row-group controller: AG write demux, FSM and skewed lane pops.
// Optional cycle counters enabled by ROW_GROUP_SCHED_PERF_CNT_EN.
module row_group_sched
   import row_group_sched_pkg::*;
#(
   parameter int ROUTER_COUNT = 4,
   parameter int SKEW_W       = 4
) (
   input logic             i_clk,
   input logic             i_rst,
   row_group_sched_if.slave bus
);

   localparam int ROW_ID_W = row_id_width(ROUTER_COUNT);
   localparam int CNT_W    = cnt_width(ROUTER_COUNT, SKEW_W);

   state_t                  state_q;
   state_t                  state_d;
   logic [SKEW_W-1:0]       skew_q;
   logic [ROUTER_COUNT-1:0] lane_write_en;
   logic [ROUTER_COUNT-1:0] pop_en;
   logic                    run;
   logic                    busy;
   logic                    done;
   logic                    ramp_done;
   logic                    start_ok;
   logic                    all_addr_empty;
   logic                    all_data_empty;

   assign all_addr_empty = &bus.i_lane_addr_empty;
   assign all_data_empty = &bus.i_lane_data_empty;
   assign start_ok       = (state_q == ST_IDLE) && bus.i_start;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                state_q <= ST_IDLE;
      else if (bus.i_reg_clear) state_q <= ST_IDLE;
      else                      state_q <= state_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                skew_q <= '0;
      else if (bus.i_reg_clear) skew_q <= '0;
      else if (start_ok)        skew_q <= bus.i_skew;
   end

   // Emptying wins over the ramp step, and a stall never holds off DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.i_start) state_d = ST_FETCH;
         ST_FETCH:  if (all_addr_empty && !bus.i_ag_valid) state_d = ST_RAMP;
         ST_RAMP: begin
            if (all_data_empty)               state_d = ST_DONE;
            else if (!bus.i_stall && ramp_done) state_d = ST_STREAM;
         end
         ST_STREAM: if (all_data_empty) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lane_write_en = '0;
      run           = (state_q == ST_RAMP) || (state_q == ST_STREAM);
      busy          = (state_q != ST_IDLE);
      done          = (state_q == ST_DONE);
      if (state_q == ST_FETCH && bus.i_ag_valid) begin
         for (int k = 0; k < ROUTER_COUNT; k++) begin
            lane_write_en[k] = (bus.i_row_id == ROW_ID_W'(k));
         end
      end
   end

   row_group_sched_skew_pop_gen #(
      .ROUTER_COUNT (ROUTER_COUNT),
      .SKEW_W       (SKEW_W),
      .CNT_W        (CNT_W)
   ) u_skew_pop_gen (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (bus.i_reg_clear),
      .i_run        (run),
      .i_stall      (bus.i_stall),
      .i_skew       (skew_q),
      .i_lane_empty (bus.i_lane_data_empty),
      .o_pop_en     (pop_en),
      .o_ramp_done  (ramp_done)
   );

   assign bus.o_lane_write_en = lane_write_en;
   assign bus.o_lane_pop_en   = pop_en;
   assign bus.o_state         = state_q;
   assign bus.o_busy          = busy;
   assign bus.o_done          = done;
   assign bus.o_addr_empty    = all_addr_empty;
   assign bus.o_data_empty    = all_data_empty;

`ifdef ROW_GROUP_SCHED_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] busy_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         busy_cnt_q  <= '0;
      end else if (bus.i_reg_clear || start_ok) begin
         stall_cnt_q <= '0;
         busy_cnt_q  <= '0;
      end else begin
         if (run && bus.i_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (busy && busy_cnt_q != '1)                busy_cnt_q  <= busy_cnt_q + 32'd1;
      end
   end

   assign bus.o_stall_cycles = stall_cnt_q;
   assign bus.o_busy_cycles  = busy_cnt_q;
`else
   assign bus.o_stall_cycles = '0;
   assign bus.o_busy_cycles  = '0;
`endif

endmodule

// File: tb/tb_row_group_sched.sv
// Bench for row_group_sched: directed and randomised row-group runs scored
// against a lane-FIFO environment and a transaction-level reference model.
module tb_row_group_sched;

   localparam int N  = 4;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   row_group_sched_if #(.ROUTER_COUNT(N), .SKEW_W(SW)) bus ();
   row_group_sched_if #(.ROUTER_COUNT(3), .SKEW_W(SW)) bus3 ();

   row_group_sched #(.ROUTER_COUNT(N), .SKEW_W(SW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   row_group_sched #(.ROUTER_COUNT(3), .SKEW_W(SW)) dut3 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus3)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference model state: spec-level mode, latched skew, unstalled run cycles.
   int           m_mode;
   int           m_skew;
   int           m_active;
   logic [N-1:0] m_pop;
   int           m_stall;
   int           m_busy;
   int           words [N];
   int           rcyc;
   int           first_pop [N];
   int           stream_cyc;
   int           n_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_skew   = 0;
      m_active = 0;
      m_pop    = '0;
      m_stall  = 0;
      m_busy   = 0;
   endtask

   task automatic model_step(output bit entered);
      entered = 0;
      if (bus.i_reg_clear) begin
         model_reset();
      end else begin
         if ((m_mode == 2 || m_mode == 3) && bus.i_stall) m_stall++;
         if (m_mode != 0) m_busy++;
         case (m_mode)
            0: begin
               m_pop = '0;
               if (bus.i_start) begin
                  m_mode  = 1;
                  m_skew  = int'(bus.i_skew);
                  m_stall = 0;
                  m_busy  = 0;
               end
            end
            1: begin
               m_pop = '0;
               if (&bus.i_lane_addr_empty && !bus.i_ag_valid) begin
                  m_mode   = 2;
                  m_active = 0;
                  entered  = 1;
               end
            end
            2, 3: begin
               if (&bus.i_lane_data_empty) begin
                  m_mode = 4;
                  m_pop  = '0;
               end else if (bus.i_stall) begin
                  m_pop = '0;
               end else begin
                  for (int k = 0; k < N; k++)
                     m_pop[k] = (m_active >= k * m_skew) && !bus.i_lane_data_empty[k];
                  if (m_mode == 2 && m_active == (N - 1) * m_skew) m_mode = 3;
                  m_active++;
               end
            end
            default: begin
               m_mode = 0;
               m_pop  = '0;
            end
         endcase
      end
   endtask

   // One clock: advance the model, consume popped words, compare outputs.
   task automatic tick();
      logic [N-1:0] pop_cur;
      bit           entered;
      pop_cur = m_pop;
      model_step(entered);
      @(posedge clk);
      #1;
      if (entered)        rcyc = 0;
      else if (rcyc >= 0) rcyc++;
      for (int k = 0; k < N; k++) begin
         if (pop_cur[k] && words[k] > 0) words[k]--;
         bus.i_lane_data_empty[k] = (words[k] == 0);
      end
      #1;
      check("state", 32'(bus.o_state), 32'(m_mode));
      check("pop_en", 32'(bus.o_lane_pop_en), 32'(m_pop));
      check("done", 32'(bus.o_done), 32'(m_mode == 4));
      check("busy", 32'(bus.o_busy), 32'(m_mode != 0));
      check("data_empty_and", 32'(bus.o_data_empty), 32'(&bus.i_lane_data_empty));
      if (m_mode != 1) check("wr_en_outside_fetch", 32'(bus.o_lane_write_en), 32'd0);
`ifdef ROW_GROUP_SCHED_PERF_CNT_EN
      check("stall_cycles", bus.o_stall_cycles, 32'(m_stall));
      check("busy_cycles", bus.o_busy_cycles, 32'(m_busy));
`else
      check("stall_cycles", bus.o_stall_cycles, 32'd0);
      check("busy_cycles", bus.o_busy_cycles, 32'd0);
`endif
      for (int k = 0; k < N; k++)
         if (bus.o_lane_pop_en[k] === 1'b1 && first_pop[k] < 0) first_pop[k] = rcyc;
      if (bus.o_state === 3'd3 && stream_cyc < 0) stream_cyc = rcyc;
      if (bus.o_done === 1'b1) n_done++;
   endtask

   // Full group: start, AG fill through FETCH, then ramp/stream until idle.
   task automatic do_run(input int skew, input int w0, input int w1, input int w2, input int w3,
                         input int st_s, input int st_l, input int clr_at, input int rst_at);
      int           ids [4] = '{0, 1, 2, 3};
      logic [N-1:0] exp_we;
      int           budget;
      words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
      for (int k = 0; k < N; k++) begin
         bus.i_lane_data_empty[k] = (words[k] == 0);
         first_pop[k] = -1;
      end
      stream_cyc = -1;
      rcyc       = -1;
      n_done     = 0;
      bus.i_lane_addr_empty = '0;
      bus.i_ag_valid = 1'b0;
      bus.i_start    = 1'b1;
      bus.i_skew     = SW'(skew);
      tick();
      bus.i_start = 1'b0;
      bus.i_skew  = SW'($urandom);
      for (int i = 0; i < 4; i++) begin
         bus.i_ag_valid = 1'b1;
         bus.i_row_id   = 2'(ids[i]);
         #1;
         exp_we = '0;
         exp_we[ids[i]] = 1'b1;
         check("wr_en_onehot", 32'(bus.o_lane_write_en), 32'(exp_we));
         tick();
      end
      bus.i_ag_valid = 1'b0;
      bus.i_lane_addr_empty = 4'b0111;
      #1;
      check("wr_en_no_valid", 32'(bus.o_lane_write_en), 32'd0);
      check("addr_empty_and", 32'(bus.o_addr_empty), 32'd0);
      tick();
      bus.i_ag_valid = 1'b1;
      bus.i_row_id   = 2'd2;
      bus.i_lane_addr_empty = '1;
      #1;
      check("addr_empty_and", 32'(bus.o_addr_empty), 32'd1);
      tick();
      bus.i_ag_valid = 1'b0;
      tick();
      budget = 0;
      while (m_mode != 0 && budget < 300) begin
         bus.i_stall     = (rcyc >= st_s) && (rcyc < st_s + st_l);
         bus.i_reg_clear = (rcyc == clr_at);
         bus.i_ag_valid  = 1'($urandom);
         bus.i_row_id    = 2'($urandom);
         if (rcyc == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check("async_rst_state", 32'(bus.o_state), 32'd0);
            check("async_rst_pop", 32'(bus.o_lane_pop_en), 32'd0);
            model_reset();
            @(posedge clk);
            #1 rst = 1'b0;
            check("rst_held_pop", 32'(bus.o_lane_pop_en), 32'd0);
         end else begin
            tick();
         end
         budget++;
      end
      bus.i_stall     = 1'b0;
      bus.i_reg_clear = 1'b0;
      bus.i_ag_valid  = 1'b0;
      check("run_in_budget", 32'(budget < 300), 32'd1);
      check("done_pulses", 32'(n_done), 32'((clr_at < 0 && rst_at < 0) ? 1 : 0));
   endtask

   initial begin
      rst = 1'b1;
      bus.i_reg_clear = 1'b0; bus.i_start = 1'b0; bus.i_skew = '0; bus.i_stall = 1'b0;
      bus.i_ag_valid = 1'b0; bus.i_row_id = '0;
      bus.i_lane_addr_empty = '1; bus.i_lane_data_empty = '1;
      bus3.i_reg_clear = 1'b0; bus3.i_start = 1'b0; bus3.i_skew = '0; bus3.i_stall = 1'b0;
      bus3.i_ag_valid = 1'b0; bus3.i_row_id = '0;
      bus3.i_lane_addr_empty = '0; bus3.i_lane_data_empty = '1;
      for (int k = 0; k < N; k++) words[k] = 0;
      model_reset();
      rcyc = -1;
      #12 rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_state", 32'(bus.o_state), 32'd0);
      check("reset_pop", 32'(bus.o_lane_pop_en), 32'd0);
      check("reset_done", 32'(bus.o_done), 32'd0);
      check("reset_busy", 32'(bus.o_busy), 32'd0);
      check("reset_stall_cycles", bus.o_stall_cycles, 32'd0);

      // Three-lane instance: row id 3 is out of range and writes nothing.
      bus3.i_start = 1'b1;
      @(posedge clk);
      #1 bus3.i_start = 1'b0;
      check("n3_fetch", 32'(bus3.o_state), 32'd1);
      for (int id = 0; id < 4; id++) begin
         bus3.i_ag_valid = 1'b1;
         bus3.i_row_id   = 2'(id);
         #1;
         check("n3_wr_en", 32'(bus3.o_lane_write_en), (id < 3) ? (32'd1 << id) : 32'd0);
      end
      bus3.i_ag_valid = 1'b0;
      @(posedge clk);
      #1;

      do_run(2, 10, 10, 10, 10, -1, 0, -1, -1);
      check("skew2_lane0_start", 32'(first_pop[0]), 32'd1);
      check("skew2_lane1_start", 32'(first_pop[1]), 32'd3);
      check("skew2_lane2_start", 32'(first_pop[2]), 32'd5);
      check("skew2_lane3_start", 32'(first_pop[3]), 32'd7);
      check("skew2_stream_entry", 32'(stream_cyc), 32'd7);

      do_run(0, 10, 10, 10, 10, -1, 0, -1, -1);
      for (int k = 0; k < N; k++) check("skew0_start", 32'(first_pop[k]), 32'd1);
      check("skew0_stream_entry", 32'(stream_cyc), 32'd1);

      do_run(15, 10, 10, 10, 10, -1, 0, -1, -1);
      check("skew15_lane3_start", 32'(first_pop[3]), 32'd46);

      do_run(2, 10, 10, 10, 10, 2, 3, -1, -1);
      check("stall_lane0_start", 32'(first_pop[0]), 32'd1);
      check("stall_lane1_start", 32'(first_pop[1]), 32'd6);
      check("stall_lane2_start", 32'(first_pop[2]), 32'd8);
      check("stall_lane3_start", 32'(first_pop[3]), 32'd10);
`ifdef ROW_GROUP_SCHED_PERF_CNT_EN
      check("stall_total", bus.o_stall_cycles, 32'd3);
`endif

      do_run(0, 10, 10, 3, 10, -1, 0, -1, -1);
      do_run(1, 10, 10, 10, 10, -1, 0, 8, -1);
      do_run(5, 10, 10, 10, 10, -1, 0, -1, 6);
      do_run(1, 4, 4, 4, 4, -1, 0, -1, -1);

      for (int r = 0; r < 8; r++) begin
         do_run(int'($urandom_range(0, 15)),
                int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 30)), int'($urandom_range(0, 5)), -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
